// File: rtl/prefetch_unit_pkg.sv
`default_nettype none
// =============================================================================
// Module      : prefetch_unit_pkg
// Description : Shared types and constants for the decoupled fetch stage.
// Revision    : 1.0 - initial release
// =============================================================================
package prefetch_unit_pkg;

    localparam int unsigned c_XLEN       = 32;
    localparam int unsigned c_INST_BYTES = 4;

    // Fetch -> decode stage register, layout shared with the older fetch stage.
    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [c_XLEN-1:0] pc;
        logic [c_XLEN-1:0] inst;
    } fetch_entry_t;

    // No compressed instructions: fetch addresses are always word aligned.
    function automatic logic [c_XLEN-1:0] align_pc(input logic [c_XLEN-1:0] pc);
        return {pc[c_XLEN-1:2], 2'b00};
    endfunction

endpackage : prefetch_unit_pkg
`default_nettype wire

// File: rtl/prefetch_unit_if.sv
`default_nettype none
// =============================================================================
// Module      : prefetch_unit_if
// Description : Instruction-memory, redirect and IF/ID stream bundle.
// Revision    : 1.0 - initial release
// =============================================================================
interface prefetch_unit_if
    import prefetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = c_XLEN
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            if_id_valid;
    logic            if_id_ready;
    if_id_t          if_id_reg;

    // Fetch unit side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output if_id_valid,
        output if_id_reg,
        input  if_id_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  if_id_valid,
        input  if_id_reg,
        output if_id_ready
    );

endinterface : prefetch_unit_if
`default_nettype wire

// File: rtl/prefetch_unit_fetch_fifo.sv
`default_nettype none
// =============================================================================
// Module      : prefetch_unit_fetch_fifo
// Description : Synchronous FIFO with push/pop/flush, occupancy and flags.
// Revision    : 1.0 - initial release
// =============================================================================
module prefetch_unit_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    input  wire logic                     i_flush,
    output logic      [WIDTH-1:0]         o_head,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int unsigned   c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop  && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);

endmodule : prefetch_unit_fetch_fifo
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : prefetch_unit
// Description : Decoupled fetch stage: PC owner, pipelined imem reads, IF/ID FIFO.
//               Optional FETCH_STATS_EN adds stall/flush event counters.
// Revision    : 1.0 - initial release
// =============================================================================
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = c_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    prefetch_unit_if.master    bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_stall_cycles,
    output logic [31:0]        stat_flushes
`endif
);

    localparam int unsigned   c_CW     = $clog2(DEPTH) + 1;
    localparam logic [c_CW:0] c_CREDIT = (c_CW + 1)'(DEPTH);

    logic [XLEN-1:0]  r_fetch_pc;
    logic [c_CW-1:0]  r_discard;

    logic [c_CW-1:0]  w_inflight;
    logic [c_CW-1:0]  w_inflight_next;
    logic [c_CW-1:0]  w_count;
    logic [c_CW:0]    w_occupancy;
    logic [XLEN-1:0]  w_tag_head;
    logic             w_tag_full;
    logic             w_tag_empty;
    logic             w_data_full;
    logic             w_data_empty;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head_entry;

    logic             w_credit;
    logic             w_req_valid;
    logic             w_fire;
    logic             w_rsp_accept;
    logic             w_rsp_keep;
    logic             w_if_id_valid;
    logic             w_pop;

    // Requests in flight plus buffered words never exceed DEPTH, so every
    // response has a FIFO slot waiting for it.
    assign w_occupancy  = {1'b0, w_inflight} + {1'b0, w_count};
    assign w_credit     = (w_occupancy < c_CREDIT) && !w_tag_full && !w_data_full;
    assign w_req_valid  = !reset && !bus.redirect_valid && w_credit;
    assign w_fire       = w_req_valid && bus.imem_req_ready;

    // A response with no tag outstanding is a protocol error and is ignored.
    assign w_rsp_accept = bus.imem_rsp_valid && !w_tag_empty;
    assign w_rsp_keep   = w_rsp_accept && !bus.redirect_valid && (r_discard == '0);

    assign w_inflight_next = w_inflight - c_CW'(w_rsp_accept);

    assign w_if_id_valid = !w_data_empty && !bus.redirect_valid;
    assign w_pop         = w_if_id_valid && bus.if_id_ready;

    assign w_push_entry = '{pc: w_tag_head, inst: bus.imem_rsp_data};

    // Tag queue tracks the PC of every outstanding request; its occupancy is
    // the in-flight count. Never flushed: stale responses still pop their tag.
    prefetch_unit_fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_fire),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_rsp_accept),
        .i_flush     (1'b0),
        .o_head      (w_tag_head),
        .o_count     (w_inflight),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty)
    );

    prefetch_unit_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_head      (w_head_entry),
        .o_count     (w_count),
        .o_full      (w_data_full),
        .o_empty     (w_data_empty)
    );

    // On redirect every request still outstanding belongs to the old path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= align_pc(bus.redirect_pc);
            r_discard  <= w_inflight_next;
        end else begin
            if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(c_INST_BYTES);
            end
            if (w_rsp_accept && (r_discard != '0)) begin
                r_discard <= r_discard - c_CW'(1);
            end
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_id_valid    = w_if_id_valid;
    assign bus.if_id_reg      = w_data_empty ? '0 : if_id_t'(w_head_entry);

`ifdef FETCH_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flushes;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flushes      <= '0;
        end else begin
            if (w_if_id_valid && !bus.if_id_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (bus.redirect_valid && (r_flushes != '1)) begin
                r_flushes <= r_flushes + 32'd1;
            end
        end
    end

    assign stat_stall_cycles = r_stall_cycles;
    assign stat_flushes      = r_flushes;
`endif

`ifndef SYNTHESIS
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_rsp_valid && (w_inflight == '0)));
`endif

endmodule : prefetch_unit
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// =============================================================================
// Module      : tb_prefetch_unit
// Description : Scoreboard bench for prefetch_unit with a latency-configurable imem.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_prefetch_unit;
    import prefetch_unit_pkg::*;

    logic clk;
    logic reset;

    prefetch_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_flushes;
`endif

    prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flushes      (stat_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] entry(input logic [31:0] pc);
        return {pc, inst_of(pc)};
    endfunction

    // ---------------- imem model: fixed latency, grant budget ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    int          lat      = 1;
    int          budget   = 0;
    int          fire_cnt = 0;
    int          cyc      = 0;
    logic        s_fire   = 1'b0;
    logic [31:0] s_addr   = '0;

    assign bus.imem_req_ready = (budget > 0);

    always @(negedge clk) begin
        if (reset) begin
            pending.delete();
            s_fire = 1'b0;
        end else begin
            s_fire = bus.imem_req_valid && bus.imem_req_ready;
            s_addr = bus.imem_req_addr;
        end
    end

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (s_fire) begin
            pending.push_back('{addr: s_addr, due: cyc - 1 + lat});
            budget--;
            fire_cnt++;
            s_fire = 1'b0;
        end
        if (pending.size() > 0 && pending[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = inst_of(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    always @(negedge clk) begin
        if (!reset && bus.if_id_valid && bus.if_id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL if_id_unexpected: got %h, no output expected", bus.if_id_reg);
            end else begin
                mon_exp = exp_q.pop_front();
                check("if_id_entry", bus.if_id_reg, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"},   64'(bus.imem_req_valid), 64'd0);
        check({tag, "_if_id_valid"}, 64'(bus.if_id_valid),    64'd0);
        check({tag, "_req_addr"},    64'(bus.imem_req_addr),  64'h0);
        check({tag, "_if_id_reg"},   64'(bus.if_id_reg),      64'h0);
    endtask

    int f0;

    initial begin
        reset              = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_id_ready    = 1'b0;

        // ---- 1: reset values, latency 1, streaming PCs 0..12 ----
        repeat (2) tick();
        lat = 1;
        budget += 4;
        bus.if_id_ready = 1'b1;
        exp_q.push_back(entry(32'h0)); exp_q.push_back(entry(32'h4));
        exp_q.push_back(entry(32'h8)); exp_q.push_back(entry(32'hC));
        @(negedge clk);
        check_reset_outputs("rst");
        tick(); reset = 1'b0;
        @(negedge clk);
        check("t1_req_valid_c1", 64'(bus.imem_req_valid), 64'd1);
        check("t1_valid_c1",     64'(bus.if_id_valid),    64'd0);
        tick(); @(negedge clk);
        check("t1_valid_c2",     64'(bus.if_id_valid),    64'd0);
        tick(); @(negedge clk);
        check("t1_valid_c3",     64'(bus.if_id_valid),    64'd1);
        repeat (8) tick();
        check("t1_drain", 64'(exp_q.size()), 64'd0);

        // ---- 2: back-pressure, credit limit, stable head ----
        tick();
        bus.if_id_ready = 1'b0;
        budget += 8;
        f0 = fire_cnt;
        exp_q.push_back(entry(32'h10)); exp_q.push_back(entry(32'h14));
        exp_q.push_back(entry(32'h18)); exp_q.push_back(entry(32'h1C));
        repeat (10) tick();
        @(negedge clk);
        check("t2_head_mid",  64'(bus.if_id_reg),   entry(32'h10));
        check("t2_valid_mid", 64'(bus.if_id_valid), 64'd1);
        repeat (10) tick();
        @(negedge clk);
        check("t2_fires",     64'(fire_cnt - f0),      64'd4);
        check("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("t2_head_end",  64'(bus.if_id_reg),      entry(32'h10));
`ifdef FETCH_STATS_EN
        check("t2_stat_stalls", 64'(stat_stall_cycles), 64'd18);
`endif
        tick();
        budget -= 4;
        bus.if_id_ready = 1'b1;
        repeat (8) tick();
        check("t2_drain", 64'(exp_q.size()), 64'd0);

        // ---- 3: latency 3, redirect with 2 in flight ----
        tick();
        lat = 3;
        budget += 2;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        budget += 2;
        exp_q.push_back(entry(32'h100)); exp_q.push_back(entry(32'h104));
        @(negedge clk);
        check("t3_req_valid_redir",  64'(bus.imem_req_valid), 64'd0);
        check("t3_if_valid_redir",   64'(bus.if_id_valid),    64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_req_addr", 64'(bus.imem_req_addr), 64'h100);
`ifdef FETCH_STATS_EN
        check("t3_stat_flushes", 64'(stat_flushes), 64'd1);
`endif
        repeat (12) tick();
        check("t3_drain", 64'(exp_q.size()), 64'd0);

        // ---- 4: redirect coincident with response and pop ----
        tick();
        lat = 1;
        bus.if_id_ready = 1'b0;
        budget += 2;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        bus.if_id_ready    = 1'b1;
        budget += 1;
        exp_q.push_back(entry(32'h300));
        @(negedge clk);
        check("t4_if_valid_redir",  64'(bus.if_id_valid),    64'd0);
        check("t4_req_valid_redir", 64'(bus.imem_req_valid), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_fifo_empty", 64'(bus.if_id_valid), 64'd0);
        repeat (8) tick();
        check("t4_drain", 64'(exp_q.size()), 64'd0);

        // ---- 5: misaligned redirect, then wrap at top of address space ----
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0403;
        budget += 1;
        exp_q.push_back(entry(32'h400));
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_aligned_addr", 64'(bus.imem_req_addr), 64'h400);
        repeat (6) tick();
        check("t5a_drain", 64'(exp_q.size()), 64'd0);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        budget += 2;
        exp_q.push_back(entry(32'hFFFF_FFFC)); exp_q.push_back(entry(32'h0));
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_top_addr", 64'(bus.imem_req_addr), 64'hFFFF_FFFC);
        repeat (8) tick();
        check("t5b_drain", 64'(exp_q.size()), 64'd0);

        // ---- 6: reset with requests in flight and a word buffered ----
        tick();
        lat = 3;
        bus.if_id_ready = 1'b0;
        budget += 3;
        repeat (3) tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        tick();
        lat = 1;
        budget += 1;
        bus.if_id_ready = 1'b1;
        exp_q.push_back(entry(32'h0));
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("t6_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_prefetch_unit
`default_nettype wire
